// File: rtl/page_table_walker_if.sv
// Handshake bundle between the TLB miss path, the page table walker and the PTE memory port.
// master = TLB plus memory side, slave = walker.
interface page_table_walker_if;
    logic        walk_req_valid_i;
    logic        walk_req_ready_o;
    logic [31:0] walk_vaddr_i;
    logic        walk_resp_valid_o;
    logic        walk_resp_ready_i;
    logic [31:0] walk_paddr_o;
    logic [2:0]  walk_perm_o;
    logic        walk_super_o;
    logic        walk_fault_o;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [31:0] mem_addr_o;
    logic        mem_resp_valid_i;
    logic        mem_resp_ready_o;
    logic [31:0] mem_data_i;

    modport master (
        output walk_req_valid_i, walk_vaddr_i, walk_resp_ready_i,
               mem_req_ready_i, mem_resp_valid_i, mem_data_i,
        input  walk_req_ready_o, walk_resp_valid_o, walk_paddr_o, walk_perm_o,
               walk_super_o, walk_fault_o, mem_req_valid_o, mem_addr_o, mem_resp_ready_o
    );

    modport slave (
        input  walk_req_valid_i, walk_vaddr_i, walk_resp_ready_i,
               mem_req_ready_i, mem_resp_valid_i, mem_data_i,
        output walk_req_ready_o, walk_resp_valid_o, walk_paddr_o, walk_perm_o,
               walk_super_o, walk_fault_o, mem_req_valid_o, mem_addr_o, mem_resp_ready_o
    );
endinterface

// File: rtl/page_table_walker.sv
// Two-level page table walker: one walk at a time, root then level-0 PTE reads over a
// valid/ready memory port, returning physical address, {X,W,R} permissions and fault status.
module page_table_walker #(
    parameter logic [31:0] ROOT_BASE = 32'h0000_0400
) (
    input  logic               clk,
    input  logic               rst,
    page_table_walker_if.slave bus
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] L1_REQ  = 3'd1;
    localparam logic [2:0] L1_WAIT = 3'd2;
    localparam logic [2:0] L0_REQ  = 3'd3;
    localparam logic [2:0] L0_WAIT = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    logic [2:0]  state;
    logic [21:0] vaddr_lo;
    logic [31:0] mem_addr;
    logic [31:0] paddr;
    logic [2:0]  perm;
    logic        super_pg;
    logic        fault;

    logic        req_fire;
    logic        mem_req_fire;
    logic        mem_resp_fire;
    logic        resp_fire;
    logic        pte_valid;
    logic        pte_leaf;
    logic [31:0] next_base;

    // Ready is gated by rst so it rises on the first cycle after reset is released.
    assign bus.walk_req_ready_o  = (state == IDLE) && !rst;
    assign bus.mem_req_valid_o   = (state == L1_REQ) || (state == L0_REQ);
    assign bus.mem_resp_ready_o  = (state == L1_WAIT) || (state == L0_WAIT);
    assign bus.walk_resp_valid_o = (state == DONE);
    assign bus.mem_addr_o        = mem_addr;
    assign bus.walk_paddr_o      = paddr;
    assign bus.walk_perm_o       = perm;
    assign bus.walk_super_o      = super_pg;
    assign bus.walk_fault_o      = fault;

    assign req_fire      = bus.walk_req_valid_i && bus.walk_req_ready_o;
    assign mem_req_fire  = bus.mem_req_valid_o && bus.mem_req_ready_i;
    assign mem_resp_fire = bus.mem_resp_valid_i && bus.mem_resp_ready_o;
    assign resp_fire     = bus.walk_resp_valid_o && bus.walk_resp_ready_i;

    assign pte_valid = bus.mem_data_i[0];
    assign pte_leaf  = |bus.mem_data_i[3:1];
    assign next_base = {bus.mem_data_i[31:4], 4'b0000};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            vaddr_lo <= '0;
            mem_addr <= '0;
            paddr    <= '0;
            perm     <= '0;
            super_pg <= 1'b0;
            fault    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        vaddr_lo <= bus.walk_vaddr_i[21:0];
                        mem_addr <= ROOT_BASE + {20'd0, bus.walk_vaddr_i[31:22], 2'b00};
                        state    <= L1_REQ;
                    end
                end
                L1_REQ: begin
                    if (mem_req_fire) state <= L1_WAIT;
                end
                L1_WAIT: begin
                    if (mem_resp_fire) begin
                        if (!pte_valid) begin
                            fault <= 1'b1;
                            state <= DONE;
                        end else if (pte_leaf) begin
                            paddr    <= {bus.mem_data_i[31:22], vaddr_lo};
                            perm     <= bus.mem_data_i[3:1];
                            super_pg <= 1'b1;
                            state    <= DONE;
                        end else begin
                            // The pointer base is folded straight into the level-0 PTE address.
                            mem_addr <= next_base + {20'd0, vaddr_lo[21:12], 2'b00};
                            state    <= L0_REQ;
                        end
                    end
                end
                L0_REQ: begin
                    if (mem_req_fire) state <= L0_WAIT;
                end
                L0_WAIT: begin
                    if (mem_resp_fire) begin
                        if (pte_valid && pte_leaf) begin
                            paddr    <= {bus.mem_data_i[31:12], vaddr_lo[11:0]};
                            perm     <= bus.mem_data_i[3:1];
                            super_pg <= 1'b0;
                        end else begin
                            fault <= 1'b1;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (resp_fire) begin
                        paddr    <= '0;
                        perm     <= '0;
                        super_pg <= 1'b0;
                        fault    <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
